mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller for the 16-bit WISC datapath, directly downstream of the execute ALU. It consumes the ALU result (as address or pass-through value) plus store data. It sequences a handshaked, variable-latency data memory and presents one write-back record per instruction. It stalls execute while an access is outstanding, flags misaligned, timed-out and halt conditions, and is the single point where memory latency enters the pipeline.

## Interface
- TIMEOUT, 255: max cycles in WAIT before abort; counter width 8.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store; never set together with ex_mem_read.
- ex_halt  in  1  instruction is HALT.
- ex_res  in  16  ALU result: effective address for loads/stores, write-back value otherwise.
- ex_wdata  in  16  store data (Rd value).
- ex_rd  in  3  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- stall_ex  out  1  execute must hold its instruction; combinational from state.
- mem_req  out  1  memory request, registered.
- mem_wr  out  1  1 = write, registered.
- mem_addr  out  16  word address, registered.
- mem_wdata  out  16  registered.
- mem_busy  in  1  memory cannot accept a request this cycle.
- mem_done  in  1  single-cycle response pulse.
- mem_rdata  in  16  read data, valid with mem_done.
- wb_valid  out  1  write-back record valid, one-cycle pulse.
- wb_data  out  16  write-back value.
- wb_rd  out  3.
- wb_reg_write  out  1.
- err  out  1  pulses with wb_valid on misalignment or timeout.
- halted  out  1  sticky once HALT retires.

## Operation
- States: IDLE, ISSUE, WAIT, HALT. stall_ex = (state != IDLE).
- Accept when state==IDLE && ex_valid. ex_rd and ex_reg_write are latched on accept.
- Non-memory, non-halt op: next cycle wb_valid=1, wb_data=ex_res, wb_rd/wb_reg_write as latched. State stays IDLE.
- Load/store with ex_res[0]==1 (misaligned): no memory request. Next cycle wb_valid=1, err=1, wb_reg_write=0, wb_data=0. State stays IDLE.
- Aligned load/store: latch address, data and wr. Go to ISSUE.
- ISSUE: mem_req=1. If mem_busy=0, the request is accepted: go to WAIT and clear the timeout counter. If mem_busy=1, hold ISSUE with the request unchanged.
- WAIT: mem_req=0. The counter increments each cycle.
  - On mem_done: capture mem_rdata and go to IDLE. Next cycle wb_valid=1 with wb_data=mem_rdata (load) or 0 (store); wb_reg_write=latched value for a load, 0 for a store.
  - If the counter reaches TIMEOUT with no mem_done: go to IDLE. Next cycle wb_valid=1, err=1, wb_reg_write=0.
- mem_done outside WAIT is ignored. This covers late responses after a timeout or reset.
- HALT accepted in IDLE: next cycle wb_valid=1, wb_reg_write=0, halted=1. Enter HALT. Stay in HALT with stall_ex=1 until rst.
- mem_rdata is only sampled on mem_done in WAIT.

## Timing
- Reset: state=IDLE, counter=0. All outputs 0, including mem_req, mem_wr, mem_addr, mem_wdata, wb_*, err and halted.
- Reset mid-access drops the outstanding access. No wb_valid is produced for it.
- Non-memory op accepted at cycle N: wb_valid at N+1. Back-to-back acceptance every cycle.
- Memory op accepted at N with mem_busy low at N+1: mem_req high at N+1, WAIT from N+2.
  - mem_done at N+1+k (k≥1): wb_valid at N+2+k; stall_ex high N+1..N+1+k.
  - The next instruction is accepted at N+2+k.
- Each busy cycle in ISSUE adds one cycle.
- Timeout: the abort fires on the TIMEOUT-th WAIT cycle without done; wb_valid/err follow one cycle later.
- mem_done arriving in the same cycle the counter reaches TIMEOUT: done wins, and the access completes normally.
- wb_valid is never asserted in two consecutive cycles for the same instruction. At most one record per accepted instruction.

## Test plan
- ADD result 0x1234 to rd=3, reg_write=1, three back-to-back ops → wb_valid on three consecutive cycles, first wb_data=0x1234, wb_rd=3, stall_ex never high.
- Load addr 0x0040, mem_busy=0, mem_done 3 cycles after mem_req with rdata 0xBEEF → mem_req one cycle with mem_addr=0x0040, mem_wr=0; stall_ex high 4 cycles; wb_data=0xBEEF, wb_reg_write=1.
- Store addr 0x0010 data 0xA5A5, mem_busy high 2 cycles → mem_req held 3 cycles with mem_wr=1, mem_wdata=0xA5A5; wb_valid with wb_reg_write=0, err=0.
- Load addr 0x0011 → no mem_req; wb_valid=1, err=1, wb_reg_write=0 one cycle after accept.
- Load, mem_done never asserted, TIMEOUT=255 → err pulse after 255 WAIT cycles. A mem_done injected afterwards produces no wb_valid.
- HALT, then rst asserted mid-load in a second run → halted=1 and stall_ex stuck high until rst. After rst, all outputs 0 and a following ADD completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage of the 16-bit WISC pipeline.
// Takes the execute result and either retires it straight to write-back
// or runs a handshaked, variable-latency data-memory access first. Execute
// is stalled while an access is in flight, or forever once HALT retires.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  // execute side
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_halt,
  input  logic [15:0] ex_res,
  input  logic [15:0] ex_wdata,
  input  logic [2:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall_ex,
  // data memory side
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  // write-back side
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        err,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // The abort fires on the WAIT cycle whose increment would bring the
  // counter to TIMEOUT, i.e. the TIMEOUT-th WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       rd_reg;
  logic             reg_write_reg;
  logic             is_mem_op;

  assign is_mem_op = ex_mem_read | ex_mem_write;

  // Execute may only advance while no access is outstanding.
  assign stall_ex = (state_reg != IDLE);

  // Controller FSM; every memory and write-back output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rd_reg        <= '0;
      reg_write_reg <= 1'b0;
      mem_req       <= 1'b0;
      mem_wr        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      err           <= 1'b0;
      halted        <= 1'b0;
    end else begin
      // Record strobes are single-cycle pulses.
      wb_valid <= 1'b0;
      err      <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            rd_reg        <= ex_rd;
            reg_write_reg <= ex_reg_write;
            if (ex_halt) begin
              // HALT retires as a record that writes nothing, then parks.
              wb_valid     <= 1'b1;
              wb_data      <= '0;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
              halted       <= 1'b1;
              state_reg    <= HALT;
            end else if (!is_mem_op) begin
              // Pass-through: the ALU result is the write-back value.
              wb_valid     <= 1'b1;
              wb_data      <= ex_res;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end else if (ex_res[0]) begin
              // Odd word address: reject without touching memory.
              wb_valid     <= 1'b1;
              err          <= 1'b1;
              wb_data      <= '0;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
            end else begin
              mem_req   <= 1'b1;
              mem_wr    <= ex_mem_write;
              mem_addr  <= ex_res;
              mem_wdata <= ex_wdata;
              state_reg <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // Request stays up, unchanged, until memory stops reporting busy.
          if (!mem_busy) begin
            mem_req   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem_done) begin
            // A response on the last allowed cycle still counts as success.
            wb_valid     <= 1'b1;
            wb_data      <= mem_wr ? 16'h0000 : mem_rdata;
            wb_rd        <= rd_reg;
            wb_reg_write <= reg_write_reg & ~mem_wr;
            state_reg    <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            wb_valid     <= 1'b1;
            err          <= 1'b1;
            wb_data      <= '0;
            wb_rd        <= rd_reg;
            wb_reg_write <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        HALT: begin
          // Only reset leaves this state.
          state_reg <= HALT;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
